// File: rtl/inv_part_exerciser.sv
// Exhaustive vector driver/checker for a multi-channel inverter part (Y = ~A).
// Latency: 2^CHANNELS*(SETTLE+2) busy cycles per run, then a one-cycle done pulse.
// Backpressure: none; start is only honoured in IDLE and is dropped otherwise.
module inv_part_exerciser #(
    parameter int CHANNELS = 5,
    parameter int SETTLE   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [CHANNELS-1:0] drive,
    input  logic [CHANNELS-1:0] sense,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CHANNELS:0]   err_count,
    output logic [CHANNELS-1:0] fail_mask
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [CHANNELS:0] LAST_VEC = {1'b0, {CHANNELS{1'b1}}};
    localparam logic [CHANNELS:0] ONE      = {{CHANNELS{1'b0}}, 1'b1};
    localparam logic [3:0]        SETTLE_L = 4'(SETTLE);

    state_t              state;
    logic [CHANNELS:0]   vec;
    logic [3:0]          settle_cnt;
    logic [CHANNELS-1:0] miss;

    // A healthy channel returns the complement of what is driven on it.
    assign miss = sense ^ ~drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            drive      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err_count <= '0;
                        fail_mask <= '0;
                        vec       <= '0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    drive      <= vec[CHANNELS-1:0];
                    settle_cnt <= SETTLE_L;
                    state      <= WAIT;
                end
                WAIT: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    fail_mask <= fail_mask | miss;
                    if (miss != '0) begin
                        err_count <= err_count + ONE;
                    end
                    if (vec == LAST_VEC) begin
                        // Verdict includes this final sample so it is valid alongside done.
                        pass  <= (err_count == '0) && (miss == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        vec   <= vec + ONE;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_part_exerciser.sv
// Bench for inv_part_exerciser: fault-injecting part models, one scoreboard for three instances.
module tb_inv_part_exerciser;

    typedef struct {
        int tag;
        int err;
        int mask;
        int pass;
        int drv;
        int len;
        int gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n0, rst_n1;
    logic [2:0] start_w;
    logic [4:0] drv   [3];
    logic [4:0] sense [3];
    logic [2:0] busy_w, done_w, pass_w;
    logic [5:0] err_w [3];
    logic [4:0] mask_w[3];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   mode = 0;
    int   ndone0 = 0;
    exp_t expq[$];
    int   acc [3];
    int   last[3];
    int   dcnt[3];
    logic [2:0] pbusy = 3'b000;

    logic [4:0] c1_0 = '1, c1_1 = '1, c1_2 = '1;
    logic [4:0] c2_0 = '1, c2_1 = '1, c2_2 = '1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inv_part_exerciser u_dut0 (
        .clk(clk), .rst_n(rst_n0), .start(start_w[0]), .drive(drv[0]), .sense(sense[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]), .fail_mask(mask_w[0])
    );
    inv_part_exerciser #(.CHANNELS(5), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .start(start_w[1]), .drive(drv[1]), .sense(sense[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]), .fail_mask(mask_w[1])
    );
    inv_part_exerciser #(.CHANNELS(5), .SETTLE(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n1), .start(start_w[2]), .drive(drv[2]), .sense(sense[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]), .fail_mask(mask_w[2])
    );

    // Part models: zero-delay with selectable faults, and two 3-cycle delayed inverters.
    always_comb begin
        sense[0] = ~drv[0];
        case (mode)
            1:       sense[0] = ~drv[0] & 5'b11011;
            2:       sense[0] = (~drv[0] & 5'b11011) | 5'b10000;
            3:       sense[0] = drv[0];
            default: sense[0] = ~drv[0];
        endcase
    end

    always @(posedge clk) begin
        c1_0 <= ~drv[1]; c1_1 <= c1_0; c1_2 <= c1_1;
        c2_0 <= ~drv[2]; c2_1 <= c2_0; c2_2 <= c2_1;
    end
    assign sense[1] = c1_2;
    assign sense[2] = c2_2;

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse and checks the run result.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (busy_w[k] && !pbusy[k]) acc[k] <= cyc;
            if (done_w[k]) begin
                if (expq.size() == 0) begin
                    chk($sformatf("unexpected_done[%0d]", k), 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk($sformatf("dut_tag[%0d]", k), k, e.tag);
                    chk($sformatf("err_count[%0d]", k), int'(err_w[k]), e.err);
                    chk($sformatf("fail_mask[%0d]", k), int'(mask_w[k]), e.mask);
                    chk($sformatf("pass[%0d]", k), int'(pass_w[k]), e.pass);
                    chk($sformatf("drive_end[%0d]", k), int'(drv[k]), e.drv);
                    chk($sformatf("busy_at_done[%0d]", k), int'(busy_w[k]), 0);
                    chk($sformatf("run_length[%0d]", k), cyc - acc[k], e.len);
                    if (e.gap != 0) chk($sformatf("done_gap[%0d]", k), cyc - last[k], e.gap);
                end
                dcnt[k] <= dcnt[k] + 1;
                last[k] <= cyc;
            end
            pbusy[k] <= busy_w[k];
        end
    end

    task automatic push(int tag, int err, int mask, int pass, int len, int gap);
        exp_t e;
        e.tag = tag; e.err = err; e.mask = mask; e.pass = pass;
        e.drv = 31; e.len = len; e.gap = gap;
        expq.push_back(e);
        if (tag == 0) ndone0++;
    endtask

    task automatic pulse(int k);
        @(negedge clk);
        start_w[k] = 1'b1;
        @(negedge clk);
        start_w[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done_w[k]) break;
        end
        chk($sformatf("done_seen[%0d]", k), int'(done_w[k]), 1);
    endtask

    task automatic run_main(int m, int err, int mask, int pass);
        mode = m;
        push(0, err, mask, pass, 128, 0);
        pulse(0);
        wait_done(0, 200);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            acc[k] = 0; last[k] = 0; dcnt[k] = 0;
        end
        start_w = 3'b000;
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        #12;
        chk("rst_drive", int'(drv[0]), 0);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_done", int'(done_w[0]), 0);
        chk("rst_pass", int'(pass_w[0]), 0);
        chk("rst_err", int'(err_w[0]), 0);
        chk("rst_mask", int'(mask_w[0]), 0);
        @(negedge clk);
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;

        // Ideal part, stuck-at faults, buffer part, then ideal again.
        run_main(0, 0, 5'b00000, 1);
        run_main(1, 16, 5'b00100, 0);
        run_main(2, 24, 5'b10100, 0);
        run_main(3, 32, 5'b11111, 0);
        run_main(0, 0, 5'b00000, 1);

        // Abandon a run with reset at cycle 50; outputs must clear without a clock edge.
        mode = 0;
        pulse(0);
        repeat (49) @(negedge clk);
        rst_n0 = 1'b0;
        #1;
        chk("midrst_drive", int'(drv[0]), 0);
        chk("midrst_busy", int'(busy_w[0]), 0);
        chk("midrst_done", int'(done_w[0]), 0);
        chk("midrst_pass", int'(pass_w[0]), 0);
        chk("midrst_err", int'(err_w[0]), 0);
        chk("midrst_mask", int'(mask_w[0]), 0);
        repeat (3) @(negedge clk);
        rst_n0 = 1'b1;
        run_main(0, 0, 5'b00000, 1);

        // Start pulses while busy and during the done cycle are dropped.
        mode = 2;
        push(0, 24, 5'b10100, 0, 128, 0);
        pulse(0);
        repeat (8) @(negedge clk);
        pulse(0);
        repeat (48) @(negedge clk);
        pulse(0);
        wait_done(0, 200);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_restart_busy", int'(busy_w[0]), 0);
        chk("done_pulses", dcnt[0], ndone0);

        // start held high: back-to-back runs, done every 130 cycles.
        mode = 0;
        push(0, 0, 0, 1, 128, 0);
        push(0, 0, 0, 1, 128, 130);
        push(0, 0, 0, 1, 128, 130);
        @(negedge clk);
        start_w[0] = 1'b1;
        wait_done(0, 200);
        wait_done(0, 200);
        wait_done(0, 200);
        start_w[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_stop_busy", int'(busy_w[0]), 0);
        chk("held_done_pulses", dcnt[0], ndone0);

        // 3-cycle part delay: SETTLE=1 samples the previous vector's response
        // (every vector but the first fails), SETTLE=3 is just long enough.
        push(1, 31, 5'b11111, 0, 96, 0);
        pulse(1);
        wait_done(1, 200);
        push(2, 0, 5'b00000, 1, 160, 0);
        pulse(2);
        wait_done(2, 300);

        repeat (5) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
